muldiv_seq: RTL and testbench

- Multi-cycle iterative multiply/divide unit for the ALU; implements MUL, IMUL, DIV and IDIV for byte and word operands.
- Radix-2, one quotient or product bit per clock.
- Uses a start/busy/done handshake so the sequencer stalls until the result is valid.
- Generalised to a WIDTH-bit word (byte = WIDTH/2).
- Adds divide-error detection (divide by zero, quotient overflow) as a dedicated output.

---
 rtl/muldiv_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply/divide unit (MUL, IMUL, DIV, IDIV) for byte and word operands.
// One product or quotient bit per clock, start/busy/done handshake, divide-error output.
module muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           func,
    input  logic                 word_op,
    input  logic [2*WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]     y,
    output logic [2*WIDTH-1:0]   out,
    output logic                 cfo,
    output logic                 ofo,
    output logic                 busy,
    output logic                 done,
    output logic                 div_exc
);

    // state  | meaning
    // IDLE   | waiting for start, operands latched on accept
    // LOAD   | magnitudes and signs taken, early divide-error check
    // CALC   | one shift-add / shift-subtract step per cycle, cnt counts down
    // FIX    | signs applied, IDIV range check, results registered
    // FIN    | done pulse with results valid, back to IDLE

    localparam int W  = WIDTH;
    localparam int B  = WIDTH / 2;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_FIX,
        S_FIN
    } state_t;

    state_t state, state_nx;

    logic [1:0]     func_lat;
    logic           word_lat;
    logic [2*W-1:0] x_lat;
    logic [W-1:0]   y_lat;
    logic           sign_a;
    logic           sign_b;
    logic           ovf_pend;
    logic [2*W-1:0] acc;
    logic [W-1:0]   q;
    logic [W-1:0]   dvs;
    logic [CW-1:0]  cnt;

    logic           is_div;
    logic           is_signed;
    logic [W-1:0]   mask_n;
    logic [2*W-1:0] mask_2n;

    logic [W-1:0]   a_raw, a_mag, b_raw, b_mag;
    logic           a_neg, b_neg;
    logic [2*W-1:0] d_raw, d_mag;
    logic           d_neg;
    logic [W-1:0]   d_hi, d_lo;
    logic           early_exc;

    logic [2*W-1:0] add_term, acc_mul;
    logic [W:0]     trial;
    logic           sub_ok;
    logic [W-1:0]   rem_nx;

    logic [2*W-1:0] prod_s, mul_out, div_out;
    logic           mul_flag;
    logic [W-1:0]   quo_s, rem_s;
    logic           q_big;
    logic           fix_exc;

    assign is_div    = func_lat[1];
    assign is_signed = func_lat[0];
    assign mask_n    = word_lat ? {W{1'b1}} : {{B{1'b0}}, {B{1'b1}}};
    assign mask_2n   = word_lat ? {2*W{1'b1}} : {{W{1'b0}}, {W{1'b1}}};

    // Operand preparation: magnitudes within the active N / 2N bits
    always_comb begin
        a_raw = x_lat[W-1:0] & mask_n;
        a_neg = is_signed & (word_lat ? x_lat[W-1] : x_lat[B-1]);
        a_mag = (a_neg ? -a_raw : a_raw) & mask_n;

        b_raw = y_lat & mask_n;
        b_neg = is_signed & (word_lat ? y_lat[W-1] : y_lat[B-1]);
        b_mag = (b_neg ? -b_raw : b_raw) & mask_n;

        d_raw = x_lat & mask_2n;
        d_neg = is_signed & (word_lat ? x_lat[2*W-1] : x_lat[W-1]);
        d_mag = (d_neg ? -d_raw : d_raw) & mask_2n;

        d_hi = word_lat ? d_mag[2*W-1:W] : {{B{1'b0}}, d_mag[W-1:B]};
        d_lo = word_lat ? d_mag[W-1:0]   : {d_mag[B-1:0], {B{1'b0}}};

        // Unsigned quotient cannot fit in N bits when high half >= divisor
        early_exc = is_div & ((b_mag == '0) | (~is_signed & (d_hi >= b_mag)));
    end

    // Iteration step; q is left-aligned so its MSB is always the next bit
    always_comb begin
        add_term = q[W-1] ? {{W{1'b0}}, dvs} : '0;
        acc_mul  = {acc[2*W-2:0], 1'b0} + add_term;
        trial    = {acc[W-1:0], q[W-1]};
        sub_ok   = trial >= {1'b0, dvs};
        rem_nx   = sub_ok ? (trial[W-1:0] - dvs) : trial[W-1:0];
    end

    // Sign fix-up and flag generation
    always_comb begin
        prod_s = (is_signed & (sign_a ^ sign_b)) ? -acc : acc;
        if (word_lat) begin
            mul_out  = prod_s;
            mul_flag = is_signed ? (prod_s[2*W-1:W] != {W{prod_s[W-1]}})
                                 : (prod_s[2*W-1:W] != '0);
        end else begin
            mul_out  = {{W{1'b0}}, prod_s[W-1:0]};
            mul_flag = is_signed ? (prod_s[W-1:B] != {B{prod_s[B-1]}})
                                 : (prod_s[W-1:B] != '0);
        end

        quo_s = (is_signed & (sign_a ^ sign_b)) ? -q : q;
        rem_s = (is_signed & sign_a) ? -acc[W-1:0] : acc[W-1:0];
        if (word_lat) begin
            div_out = {rem_s, quo_s};
            q_big   = q[W-1];
        end else begin
            div_out = {{W{1'b0}}, rem_s[B-1:0], quo_s[B-1:0]};
            q_big   = q[W-1:B-1] != '0;
        end

        // Magnitude 2^(N-1) faults for both signs, matching 8086 IDIV
        fix_exc = is_div & is_signed & (ovf_pend | q_big);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_LOAD;
            S_LOAD: state_nx = early_exc ? S_FIN : S_CALC;
            S_CALC: if (cnt == CW'(1)) state_nx = S_FIX;
            S_FIX:  state_nx = S_FIN;
            S_FIN:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            func_lat <= '0;
            word_lat <= 1'b0;
            x_lat    <= '0;
            y_lat    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            ovf_pend <= 1'b0;
            acc      <= '0;
            q        <= '0;
            dvs      <= '0;
            cnt      <= '0;
            out      <= '0;
            cfo      <= 1'b0;
            ofo      <= 1'b0;
            div_exc  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        func_lat <= func;
                        word_lat <= word_op;
                        x_lat    <= x;
                        y_lat    <= y;
                    end
                end
                S_LOAD: begin
                    sign_a   <= is_div ? d_neg : a_neg;
                    sign_b   <= b_neg;
                    ovf_pend <= is_div & is_signed & (d_hi >= b_mag);
                    cnt      <= word_lat ? CW'(W) : CW'(B);
                    if (is_div) begin
                        acc <= {{W{1'b0}}, d_hi};
                        q   <= d_lo;
                        dvs <= b_mag;
                    end else begin
                        acc <= '0;
                        q   <= word_lat ? b_mag : (b_mag << B);
                        dvs <= a_mag;
                    end
                    if (early_exc) begin
                        out     <= '0;
                        cfo     <= 1'b0;
                        ofo     <= 1'b0;
                        div_exc <= 1'b1;
                    end
                end
                S_CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        acc <= {{W{1'b0}}, rem_nx};
                        q   <= {q[W-2:0], sub_ok};
                    end else begin
                        acc <= acc_mul;
                        q   <= {q[W-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    out     <= fix_exc ? '0 : (is_div ? div_out : mul_out);
                    cfo     <= ~is_div & mul_flag;
                    ofo     <= ~is_div & mul_flag;
                    div_exc <= fix_exc;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_FIN);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed results, latencies, divide errors,
// handshake behaviour and mid-operation reset.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  func;
    logic        word_op;
    logic [31:0] x;
    logic [15:0] y;
    logic [31:0] out;
    logic        cfo;
    logic        ofo;
    logic        busy;
    logic        done;
    logic        div_exc;

    int errors = 0;
    int checks = 0;
    int lat;
    int ndone;
    int first_done;
    logic [31:0] cap_out;

    localparam logic [1:0] F_MUL = 2'b00, F_IMUL = 2'b01, F_DIV = 2'b10, F_IDIV = 2'b11;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .func    (func),
        .word_op (word_op),
        .x       (x),
        .y       (y),
        .out     (out),
        .cfo     (cfo),
        .ofo     (ofo),
        .busy    (busy),
        .done    (done),
        .div_exc (div_exc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation; returns at the negedge of the done cycle (or after timeout, lat=-1)
    task automatic do_op(input logic [1:0] f, input logic w, input logic [31:0] xv,
                         input logic [15:0] yv, output int latency);
        int c;
        @(negedge clk);
        func = f; word_op = w; x = xv; y = yv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; func = ~f; word_op = ~w; x = 32'hA5A5_5A5A; y = 16'h3C3C;
        latency = -1;
        c = 1;
        while (latency < 0 && c <= 40) begin
            if (done) latency = c;
            else begin
                @(negedge clk);
                c++;
            end
        end
    endtask

    task automatic expect_res(input string tag, input int latency, input int exp_lat,
                              input logic [31:0] exp_out, input logic exp_flag, input logic exp_exc);
        check({tag, ".latency"}, 64'(latency), 64'(exp_lat));
        check({tag, ".out"},     64'(out),     64'(exp_out));
        check({tag, ".cfo"},     64'(cfo),     64'(exp_flag));
        check({tag, ".ofo"},     64'(ofo),     64'(exp_flag));
        check({tag, ".div_exc"}, 64'(div_exc), 64'(exp_exc));
        check({tag, ".busy"},    64'(busy),    64'(1));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; func = 2'b00; word_op = 1'b0; x = '0; y = '0;
        repeat (3) @(negedge clk);
        check("reset.out",     64'(out),     64'(0));
        check("reset.busy",    64'(busy),    64'(0));
        check("reset.done",    64'(done),    64'(0));
        check("reset.div_exc", 64'(div_exc), 64'(0));
        check("reset.cfo",     64'(cfo),     64'(0));
        rst = 1'b0;

        do_op(F_MUL, 1'b0, 32'h0000_00FF, 16'h00FF, lat);
        expect_res("mul_byte_ff", lat, 11, 32'h0000_FE01, 1'b1, 1'b0);

        // issued in the cycle right after the previous done
        do_op(F_IMUL, 1'b1, 32'h0000_FFFE, 16'h0003, lat);
        expect_res("imul_word", lat, 19, 32'hFFFF_FFFA, 1'b0, 1'b0);

        do_op(F_IDIV, 1'b1, 32'hFFFF_FFF9, 16'h0002, lat);
        expect_res("idiv_word_trunc", lat, 19, 32'hFFFF_FFFD, 1'b0, 1'b0);

        do_op(F_DIV, 1'b0, 32'h0000_0064, 16'h0007, lat);
        expect_res("div_byte", lat, 11, 32'h0000_020E, 1'b0, 1'b0);

        do_op(F_IDIV, 1'b0, 32'h0000_0007, 16'h00FE, lat);
        expect_res("idiv_byte_negdiv", lat, 11, 32'h0000_01FD, 1'b0, 1'b0);

        do_op(F_DIV, 1'b1, 32'h1234_5678, 16'h0000, lat);
        expect_res("div_zero", lat, 2, 32'h0, 1'b0, 1'b1);

        do_op(F_DIV, 1'b0, 32'h0000_0400, 16'h0004, lat);
        expect_res("div_byte_ovf", lat, 2, 32'h0, 1'b0, 1'b1);

        do_op(F_IDIV, 1'b0, 32'h0000_FF80, 16'h0001, lat);
        expect_res("idiv_byte_min", lat, 11, 32'h0, 1'b0, 1'b1);

        do_op(F_IMUL, 1'b0, 32'h0000_0040, 16'h0002, lat);
        expect_res("imul_byte_ovf", lat, 11, 32'h0000_0080, 1'b1, 1'b0);

        @(negedge clk);
        check("hold.done", 64'(done), 64'(0));
        check("hold.busy", 64'(busy), 64'(0));
        check("hold.out",  64'(out),  64'(32'h0000_0080));
        check("hold.cfo",  64'(cfo),  64'(1));

        // start pulsed again mid-operation must be ignored
        @(negedge clk);
        func = F_MUL; word_op = 1'b1; x = 32'h0000_0005; y = 16'h0007; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; first_done = -1; cap_out = '0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 1) check("hs.busy_load", 64'(busy), 64'(1));
            if (done) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = c;
                    cap_out = out;
                end
            end
            if (c == 4) begin
                start = 1'b1; func = F_DIV; x = 32'h0000_0100; y = 16'h0003;
            end
            if (c == 5) start = 1'b0;
            @(negedge clk);
        end
        check("hs.num_done",   64'(ndone),      64'(1));
        check("hs.done_cycle", 64'(first_done), 64'(19));
        check("hs.out",        64'(cap_out),    64'(32'h0000_0023));
        check("hs.idle_busy",  64'(busy),       64'(0));

        // reset in cycle 5 of a word DIV aborts without done
        func = F_DIV; word_op = 1'b1; x = 32'h0001_0000; y = 16'h0003; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid.busy",    64'(busy),    64'(0));
        check("rst_mid.done",    64'(done),    64'(0));
        check("rst_mid.out",     64'(out),     64'(0));
        check("rst_mid.cfo",     64'(cfo),     64'(0));
        check("rst_mid.ofo",     64'(ofo),     64'(0));
        check("rst_mid.div_exc", 64'(div_exc), 64'(0));
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        check("rst_mid.no_done", 64'(ndone), 64'(0));

        do_op(F_MUL, 1'b1, 32'h0000_0003, 16'h0004, lat);
        expect_res("mul_after_rst", lat, 19, 32'h0000_000C, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
